regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL take parameter WIDTH, default 16, as the register and data width in bits.
REQ-002 The module SHALL take parameter REGNUM, default 16, as the number of architectural registers.
REQ-003 The module SHALL take parameter ADDRESSWIDTH, default 4, as the register address width, with REGNUM <= 2**ADDRESSWIDTH.
REQ-004 The module SHALL take parameter NRD, default 3, as the number of read ports, 1..8.
REQ-005 The module SHALL take parameter PCREG, default 7, as the register address that aliases the pc input.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port pc, input, WIDTH bits: program counter value returned for reads of PCREG.
REQ-009 Port ra, input, NRD*ADDRESSWIDTH bits: read addresses, where port i is slice [i*ADDRESSWIDTH +: ADDRESSWIDTH].
REQ-010 Port rd, output, NRD*WIDTH bits: read data, where port i is slice [i*WIDTH +: WIDTH].
REQ-011 Port pend, output, NRD bits: per read port, the addressed register awaits an outstanding write.
REQ-012 Ports we0/we1, input, 1 bit each: write enables; wa0/wa1, input, ADDRESSWIDTH bits: write addresses; wd0/wd1, input, WIDTH bits: write data.
REQ-013 Port iss_valid, input, 1 bit, with iss_addr, input, ADDRESSWIDTH bits: marks register iss_addr as pending a future write.
REQ-014 Port busy, output, 1 bit: the post-reset clear sequence is in progress.

Function
REQ-015 Reads SHALL be combinational: rd[i] = pc if ra[i]==PCREG, else bypassed write data, else the stored register.
REQ-016 Bypass SHALL be write-first: if we1 and wa1==ra[i], return wd1; else if we0 and wa0==ra[i], return wd0.
REQ-017 When we0 and we1 target the same address in the same cycle, port 1 SHALL win, both in storage and in bypass.
REQ-018 Writes to PCREG or to an address >= REGNUM SHALL be discarded; reads of an address >= REGNUM SHALL return 0.
REQ-019 The state machine SHALL have two states, CLEAR and RUN; reset forces CLEAR with the clear counter at 0.
REQ-020 In CLEAR, one register per cycle SHALL be written to 0 (address = counter); after register REGNUM-1 the state SHALL be RUN on the next edge, so CLEAR lasts exactly REGNUM cycles.
REQ-021 busy SHALL be 1 exactly while in CLEAR; in CLEAR all external writes and issues SHALL be ignored, rd SHALL be 0 (pc for PCREG), and pend SHALL be 0.
REQ-022 A per-register pending bit SHALL be set at the edge where iss_valid is 1, and cleared at the edge where either write port writes that register.
REQ-023 If an issue and a write target the same register in the same cycle, set SHALL win (a new producer supersedes).
REQ-024 pend[i] SHALL equal pending[ra[i]] and be masked to 0 when the bypass of REQ-016 hits, or when ra[i]==PCREG or ra[i] >= REGNUM.
REQ-025 An issue to PCREG or to an address >= REGNUM SHALL be ignored.

Reset
REQ-026 Assertion of rst_n low SHALL asynchronously force state CLEAR, counter 0, all pending bits 0, and busy 1.
REQ-027 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full clear sequence from register 0 after release.
REQ-028 The register array SHALL NOT be reset asynchronously; it is zeroed only by the CLEAR sequence.

Structure
REQ-029 Package regfile_pkg SHALL hold the state enum (CLEAR, RUN) and the default WIDTH, REGNUM, ADDRESSWIDTH and PCREG constants.
REQ-030 The pending-bit logic SHALL be a sub-module rf_scoreboard (set/clear/lookup, parametrised by REGNUM and NRD); storage, bypass and the FSM SHALL stay in regfile_mp.

Verification
REQ-031 Reset release: busy=1 for exactly 16 cycles, then 0; all reads of r0..r15 except r7 return 0x0000; r7 returns pc.
REQ-032 Dual write collision: we0=we1=1, wa0=wa1=3, wd0=0x1111, wd1=0x2222 -> same-cycle rd for ra=3 is 0x2222, and after the edge r3=0x2222.
REQ-033 Bypass: we0=1, wa0=5, wd0=0xBEEF with ra[0]=ra[2]=5 -> rd0=rd2=0xBEEF in the same cycle, with pend=0 on both ports.
REQ-034 Scoreboard: issue r9, then the next cycle ra=9 -> pend=1; write r9 -> cleared; issue and write r9 in the same cycle -> pend stays 1.
REQ-035 PC alias: a write of 0x5555 to r7, with pc=0x0042 -> reads of r7 return 0x0042; an issue to r7 never raises pend.
REQ-036 Mid-operation reset: rst_n low for 1 cycle while pending bits are set and registers hold data -> pend all 0 immediately, busy=1, and all registers return 0 after 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RF_WIDTH  = 16;
    localparam int RF_REGNUM = 16;
    localparam int RF_AW     = 4;
    localparam int RF_PCREG  = 7;
    localparam int RF_NRD    = 3;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared by either write port, looked up per read port.
module rf_scoreboard #(
    parameter int REGNUM       = 16,
    parameter int NRD          = 3,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        set_en,
    input  logic [ADDRESSWIDTH-1:0]     set_addr,
    input  logic                        clr0_en,
    input  logic [ADDRESSWIDTH-1:0]     clr0_addr,
    input  logic                        clr1_en,
    input  logic [ADDRESSWIDTH-1:0]     clr1_addr,
    input  logic [NRD*ADDRESSWIDTH-1:0] ra,
    output logic [NRD-1:0]              hit
);

    logic [REGNUM-1:0] pending;

    // A new producer issued in the same cycle as the old one retires keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int r = 0; r < REGNUM; r++) begin
                if (set_en && int'(set_addr) == r)
                    pending[r] <= 1'b1;
                else if ((clr0_en && int'(clr0_addr) == r) || (clr1_en && int'(clr1_addr) == r))
                    pending[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NRD; i++)
            for (int r = 0; r < REGNUM; r++)
                if (int'(ra[i*ADDRESSWIDTH +: ADDRESSWIDTH]) == r)
                    hit[i] = pending[r];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with write-first bypass, pc alias and
// a post-reset sequence that zeroes one register per cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH        = RF_WIDTH,
    parameter int REGNUM       = RF_REGNUM,
    parameter int ADDRESSWIDTH = RF_AW,
    parameter int NRD          = RF_NRD,
    parameter int PCREG        = RF_PCREG
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            pc,
    input  logic [NRD*ADDRESSWIDTH-1:0] ra,
    output logic [NRD*WIDTH-1:0]        rd,
    output logic [NRD-1:0]              pend,
    input  logic                        we0,
    input  logic [ADDRESSWIDTH-1:0]     wa0,
    input  logic [WIDTH-1:0]            wd0,
    input  logic                        we1,
    input  logic [ADDRESSWIDTH-1:0]     wa1,
    input  logic [WIDTH-1:0]            wd1,
    input  logic                        iss_valid,
    input  logic [ADDRESSWIDTH-1:0]     iss_addr,
    output logic                        busy
);

    localparam logic [ADDRESSWIDTH-1:0] PC_A   = ADDRESSWIDTH'(PCREG);
    localparam logic [ADDRESSWIDTH-1:0] LAST_A = ADDRESSWIDTH'(REGNUM - 1);

    function automatic logic addr_ok(input logic [ADDRESSWIDTH-1:0] a);
        return (int'(a) < REGNUM) && (a != PC_A);
    endfunction

    state_t                  state, state_nxt;
    logic [ADDRESSWIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]        regs [REGNUM];
    logic                    w0, w1, iss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + ADDRESSWIDTH'(1);
                if (cnt == LAST_A) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    assign w0  = we0 && !busy && addr_ok(wa0);
    assign w1  = we1 && !busy && addr_ok(wa1);
    assign iss = iss_valid && !busy && addr_ok(iss_addr);

    // Storage has no reset; the CLEAR walk is what zeroes it. Port 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (busy) begin
            regs[cnt] <= '0;
        end else begin
            if (w0) regs[wa0] <= wd0;
            if (w1) regs[wa1] <= wd1;
        end
    end

    logic [NRD-1:0][ADDRESSWIDTH-1:0] ra_v;
    logic [NRD-1:0][WIDTH-1:0]        rd_v;
    logic [NRD-1:0]                   hit0, hit1, is_pc, in_rng, pend_raw;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        assign ra_v[i]   = ra[i*ADDRESSWIDTH +: ADDRESSWIDTH];
        assign hit0[i]   = w0 && (wa0 == ra_v[i]);
        assign hit1[i]   = w1 && (wa1 == ra_v[i]);
        assign is_pc[i]  = (ra_v[i] == PC_A);
        assign in_rng[i] = (int'(ra_v[i]) < REGNUM);
    end

    always_comb begin
        rd_v = '0;
        pend = '0;
        for (int i = 0; i < NRD; i++) begin
            if (is_pc[i])                rd_v[i] = pc;
            else if (busy || !in_rng[i]) rd_v[i] = '0;
            else if (hit1[i])            rd_v[i] = wd1;
            else if (hit0[i])            rd_v[i] = wd0;
            else                         rd_v[i] = regs[ra_v[i]];
            pend[i] = pend_raw[i] && !busy && !is_pc[i] && in_rng[i] && !hit0[i] && !hit1[i];
        end
    end

    assign rd = rd_v;

    rf_scoreboard #(
        .REGNUM       (REGNUM),
        .NRD          (NRD),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (iss),
        .set_addr  (iss_addr),
        .clr0_en   (w0),
        .clr0_addr (wa0),
        .clr1_en   (w1),
        .clr1_addr (wa1),
        .ra        (ra),
        .hit       (pend_raw)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: directed vector table, clear-sequence checks and randomized traffic vs. an array model.
module tb_regfile_mp;

    localparam int W   = 16;
    localparam int R   = 16;
    localparam int AW  = 4;
    localparam int NRD = 3;
    localparam int PCR = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     pc;
    logic [NRD*AW-1:0] ra;
    logic [NRD*W-1:0] rd;
    logic [NRD-1:0]   pend;
    logic             we0, we1, iss_valid, busy;
    logic [AW-1:0]    wa0, wa1, iss_addr;
    logic [W-1:0]     wd0, wd1;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ra(ra), .rd(rd), .pend(pend),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: register contents, pending flags, clear cycles still to run.
    logic [W-1:0] mregs [R];
    logic         mpend [R];
    int           clr_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    function automatic logic ok(input logic [AW-1:0] a);
        return (int'(a) < R) && (int'(a) != PCR);
    endfunction

    function automatic logic [W-1:0] exp_rd(input int i);
        logic [AW-1:0] a;
        a = ra[i*AW +: AW];
        if (int'(a) == PCR) return pc;
        if (clr_left > 0 || int'(a) >= R) return '0;
        if (we1 && ok(wa1) && wa1 == a) return wd1;
        if (we0 && ok(wa0) && wa0 == a) return wd0;
        return mregs[a];
    endfunction

    function automatic logic exp_pend(input int i);
        logic [AW-1:0] a;
        a = ra[i*AW +: AW];
        if (clr_left > 0 || !ok(a)) return 1'b0;
        if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
        return mpend[a];
    endfunction

    function automatic void model_edge();
        if (clr_left > 0) begin
            mregs[R - clr_left] = '0;
            clr_left--;
        end else begin
            if (we0 && ok(wa0)) begin mregs[wa0] = wd0; mpend[wa0] = 1'b0; end
            if (we1 && ok(wa1)) begin mregs[wa1] = wd1; mpend[wa1] = 1'b0; end
            if (iss_valid && ok(iss_addr)) mpend[iss_addr] = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        clr_left = R;
        for (int r = 0; r < R; r++) mpend[r] = 1'b0;
    endfunction

    task automatic check_model(input string tag);
        for (int i = 0; i < NRD; i++) begin
            chk({tag, "_rd"},   64'(rd[i*W +: W]), 64'(exp_rd(i)));
            chk({tag, "_pend"}, 64'(pend[i]),      64'(exp_pend(i)));
        end
        chk({tag, "_busy"}, 64'(busy), 64'(clr_left > 0));
    endtask

    // Inputs are driven at edge+1; outputs sampled at edge+4; model follows each edge.
    task automatic cycle(input bit do_check, input string tag);
        #3;
        if (do_check) check_model(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_phase(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            we0 = 1'b1; wa0 = 4'($urandom); wd0 = 16'($urandom);
            we1 = 1'b1; wa1 = 4'($urandom); wd1 = 16'($urandom);
            iss_valid = 1'b1; iss_addr = 4'($urandom);
            ra = 12'($urandom);
            pc = 16'($urandom);
            cycle(1'b1, tag);
            n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(16));
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        logic [W-1:0] e;
        for (int a = 0; a < R; a++) begin
            ra = {3{4'(a)}};
            e = (a == PCR) ? pc : 16'h0000;
            #3;
            chk({tag, "_zero"}, 64'(rd), 64'({e, e, e}));
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    typedef struct {
        logic          we0; logic [3:0] wa0; logic [15:0] wd0;
        logic          we1; logic [3:0] wa1; logic [15:0] wd1;
        logic          iss; logic [3:0] ia;
        logic [3:0]    r0, r1, r2;
        logic [15:0]   e0, e1, e2;
        logic [2:0]    ep;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1, 3, 16'h1111, 1, 3, 16'h2222, 0, 0, 3, 3, 7, 16'h2222, 16'h2222, 16'h0042, 3'b000};
        tbl[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 0, 7, 16'h2222, 16'h0000, 16'h0042, 3'b000};
        tbl[2]  = '{1, 5, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 5, 3, 5, 16'hBEEF, 16'h2222, 16'hBEEF, 3'b000};
        tbl[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 9, 9, 5, 7, 16'h0000, 16'hBEEF, 16'h0042, 3'b000};
        tbl[4]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 9, 9, 1, 16'h0000, 16'h0000, 16'h0000, 3'b011};
        tbl[5]  = '{0, 0, 16'h0000, 1, 9, 16'h0909, 0, 0, 9, 2, 9, 16'h0909, 16'h0000, 16'h0909, 3'b000};
        tbl[6]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 9, 9, 9, 16'h0909, 16'h0909, 16'h0909, 3'b000};
        tbl[7]  = '{1, 9, 16'h0A0A, 0, 0, 16'h0000, 1, 9, 5, 3, 7, 16'hBEEF, 16'h2222, 16'h0042, 3'b000};
        tbl[8]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 9, 7, 7, 16'h0A0A, 16'h0042, 16'h0042, 3'b001};
        tbl[9]  = '{1, 7, 16'h5555, 0, 0, 16'h0000, 1, 7, 7, 3, 4, 16'h0042, 16'h2222, 16'h0000, 3'b000};
        tbl[10] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 7, 7, 16'h0042, 16'h0042, 16'h0042, 3'b000};
        tbl[11] = '{0, 0, 16'h0000, 1, 9, 16'h1234, 0, 0, 9, 9, 5, 16'h1234, 16'h1234, 16'hBEEF, 3'b000};
        tbl[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 9, 0, 15, 16'h1234, 16'h0000, 16'h0000, 3'b000};

        // Power-on reset
        rst_n = 1'b0;
        idle();
        pc = 16'h0042;
        ra = '0;
        model_reset();
        #1;
        chk("reset_busy", 64'(busy), 64'(1));
        chk("reset_pend", 64'(pend), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_phase("clr0");
        pc = 16'h0042;
        check_all_zero("clr0");

        // Directed vectors
        for (int k = 0; k < 13; k++) begin
            we0 = tbl[k].we0; wa0 = tbl[k].wa0; wd0 = tbl[k].wd0;
            we1 = tbl[k].we1; wa1 = tbl[k].wa1; wd1 = tbl[k].wd1;
            iss_valid = tbl[k].iss; iss_addr = tbl[k].ia;
            ra = {tbl[k].r2, tbl[k].r1, tbl[k].r0};
            #3;
            chk($sformatf("vec%0d_rd", k), 64'(rd), 64'({tbl[k].e2, tbl[k].e1, tbl[k].e0}));
            chk($sformatf("vec%0d_pend", k), 64'(pend), 64'(tbl[k].ep));
            @(posedge clk);
            model_edge();
            #1;
        end
        idle();

        // Randomized traffic vs. model
        for (int k = 0; k < 400; k++) begin
            we0 = 1'($urandom); wa0 = 4'($urandom); wd0 = 16'($urandom);
            we1 = 1'($urandom); wa1 = 4'($urandom); wd1 = 16'($urandom);
            iss_valid = ($urandom_range(0, 2) == 0); iss_addr = 4'($urandom);
            ra = 12'($urandom);
            if ($urandom_range(0, 7) == 0) pc = 16'($urandom);
            cycle(1'b1, "rand");
        end
        idle();

        // Reset in the middle of operation
        pc = 16'h0042;
        iss_valid = 1'b1; iss_addr = 4'd2;
        cycle(1'b1, "pre");
        idle();
        we0 = 1'b1; wa0 = 4'd4; wd0 = 16'hCAFE;
        cycle(1'b1, "pre");
        idle();
        ra = {4'd2, 4'd4, 4'd2};
        #3;
        chk("pre_rst_pend", 64'(pend), 64'(3'b101));
        chk("pre_rst_r4",   64'(rd[W +: W]), 64'(16'hCAFE));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pend", 64'(pend), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_phase("clr1");
        pc = 16'h0042;
        check_all_zero("clr1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
